// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multicycle main control FSM (FETCH/DECODE/EXEC/MEM/WB) with memory-wait timeout.
// Define CTRL_ILLEGAL_TRAP_EN to trap illegal opcodes with a sticky flag; otherwise they retire as NOPs.
module ctrl_fsm #(
    parameter int OPW         = 6,
    parameter int ALUOPW      = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OPW-1:0]    opcode,
    input  logic [OPW-1:0]    funct,
    input  logic              mem_ready,
    output logic              pc_write,
    output logic              pc_write_cond,
    output logic              branch_ne,
    output logic [1:0]        pc_src,
    output logic              iord,
    output logic              mem_read,
    output logic              mem_write,
    output logic              ir_write,
    output logic              reg_write,
    output logic [1:0]        reg_dst,
    output logic [1:0]        mem_to_reg,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [ALUOPW-1:0] ALUOp,
    output logic              instr_done,
    output logic              mem_err,
    output logic              illegal
);
`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif
    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [OPW-1:0] OP_R     = OPW'(0);
    localparam logic [OPW-1:0] OP_ANDI  = OPW'(2);
    localparam logic [OPW-1:0] OP_ORI   = OPW'(3);
    localparam logic [OPW-1:0] OP_XORI  = OPW'(4);
    localparam logic [OPW-1:0] OP_SLTI  = OPW'(5);
    localparam logic [OPW-1:0] OP_SLTIU = OPW'(6);
    localparam logic [OPW-1:0] OP_LUI   = OPW'(7);
    localparam logic [OPW-1:0] OP_LW    = OPW'(8);
    localparam logic [OPW-1:0] OP_SW    = OPW'(9);
    localparam logic [OPW-1:0] OP_BNE   = OPW'(11);
    localparam logic [OPW-1:0] OP_JAL   = OPW'(13);
    localparam logic [OPW-1:0] FN_JR    = OPW'(15);
    localparam logic [ALUOPW-1:0] AL_R    = ALUOPW'(0);
    localparam logic [ALUOPW-1:0] AL_ADD  = ALUOPW'(1);
    localparam logic [ALUOPW-1:0] AL_SUB  = ALUOPW'(2);
    localparam logic [ALUOPW-1:0] AL_AND  = ALUOPW'(3);
    localparam logic [ALUOPW-1:0] AL_OR   = ALUOPW'(4);
    localparam logic [ALUOPW-1:0] AL_XOR  = ALUOPW'(5);
    localparam logic [ALUOPW-1:0] AL_SLT  = ALUOPW'(6);
    localparam logic [ALUOPW-1:0] AL_SLTU = ALUOPW'(7);
    localparam logic [ALUOPW-1:0] AL_LUI  = ALUOPW'(8);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_MEM_ADDR,
        S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_TRAP
    } state_t;

    state_t            r_state;
    state_t            w_dec_next;
    logic [CW-1:0]     r_cnt;
    logic              r_illegal;
    logic              w_wait;
    logic              w_tmo;
    logic              w_illegal_op;
    logic              w_is_jr;
    logic [ALUOPW-1:0] w_imm_op;

    always_comb begin
        w_illegal_op = opcode > OP_JAL;
        w_is_jr      = funct == FN_JR;
        w_wait       = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
        w_tmo        = (MEM_TIMEOUT != 0) && w_wait && !mem_ready && (r_cnt == CW'(MEM_TIMEOUT - 1));
        w_dec_next   = (opcode == OP_R)   ? S_EXEC_R :
                       (opcode <= OP_LUI) ? S_EXEC_I :
                       (opcode <= OP_SW)  ? S_MEM_ADDR :
                       (opcode <= OP_BNE) ? S_BRANCH :
                       !w_illegal_op      ? S_JUMP :
                       TRAP_EN            ? S_TRAP : S_FETCH;
        w_imm_op     = (opcode == OP_ANDI)  ? AL_AND :
                       (opcode == OP_ORI)   ? AL_OR :
                       (opcode == OP_XORI)  ? AL_XOR :
                       (opcode == OP_SLTI)  ? AL_SLT :
                       (opcode == OP_SLTIU) ? AL_SLTU :
                       (opcode == OP_LUI)   ? AL_LUI : AL_ADD;
    end

    // The wait counter only survives cycles that stay in the same wait state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_cnt     <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_cnt <= (w_wait && !mem_ready && !w_tmo) ? r_cnt + CW'(1) : '0;
            if (TRAP_EN && r_state == S_DECODE && w_illegal_op) r_illegal <= 1'b1;
            unique case (r_state)
                S_FETCH:    r_state <= mem_ready ? S_DECODE : S_FETCH;
                S_DECODE:   r_state <= w_dec_next;
                S_EXEC_R:   r_state <= w_is_jr ? S_FETCH : S_WB_R;
                S_EXEC_I:   r_state <= S_WB_I;
                S_MEM_ADDR: r_state <= (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD:   r_state <= mem_ready ? S_MEM_WB : w_tmo ? S_FETCH : S_MEM_RD;
                S_MEM_WR:   r_state <= (mem_ready || w_tmo) ? S_FETCH : S_MEM_WR;
                S_TRAP:     r_state <= S_TRAP;
                default:    r_state <= S_FETCH;
            endcase
        end
    end

    // Reset forces every output low in the same cycle, abandoning any in-flight access.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        pc_src        = 2'b00;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 2'b00;
        mem_to_reg    = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        ALUOp         = AL_R;
        instr_done    = 1'b0;
        mem_err       = 1'b0;
        illegal       = r_illegal && !rst;
        if (!rst) begin
            mem_err = w_tmo;
            unique case (r_state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ALUOp     = AL_ADD;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b  = 2'b11;
                    ALUOp      = AL_ADD;
                    instr_done = w_illegal_op && !TRAP_EN;
                end
                S_EXEC_R: begin
                    alu_src_a  = 1'b1;
                    pc_write   = w_is_jr;
                    pc_src     = w_is_jr ? 2'b11 : 2'b00;
                    instr_done = w_is_jr;
                end
                S_WB_R: begin
                    reg_write  = 1'b1;
                    reg_dst    = 2'b01;
                    instr_done = 1'b1;
                end
                S_EXEC_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    ALUOp     = w_imm_op;
                end
                S_WB_I: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    ALUOp     = AL_ADD;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 2'b01;
                    instr_done = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write  = 1'b1;
                    iord       = 1'b1;
                    instr_done = mem_ready;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    ALUOp         = AL_SUB;
                    pc_write_cond = 1'b1;
                    pc_src        = 2'b01;
                    branch_ne     = opcode == OP_BNE;
                    instr_done    = 1'b1;
                end
                S_JUMP: begin
                    pc_write   = 1'b1;
                    pc_src     = 2'b10;
                    instr_done = 1'b1;
                    reg_write  = opcode == OP_JAL;
                    reg_dst    = (opcode == OP_JAL) ? 2'b10 : 2'b00;
                    mem_to_reg = (opcode == OP_JAL) ? 2'b10 : 2'b00;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ctrl_fsm.sv
// tb_ctrl_fsm: table vectors, hand corner sequences and random instruction streams for ctrl_fsm.
module tb_ctrl_fsm;
    localparam int TMO = 15;
`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] aluop;
        logic       instr_done;
        logic       mem_err;
        logic       illegal;
    } outs_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] f;
        int         lat;
        outs_t      fin;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mem_ready = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write, reg_write;
    logic       alu_src_a, instr_done, mem_err, illegal;
    logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b;
    logic [3:0] ALUOp;
    outs_t      got;

    int    n_chk = 0;
    int    n_fail = 0;
    int    m_step = 0;
    int    m_wait = 0;
    bit    m_trap = 1'b0;
    int    amap[8] = '{0, 1, 3, 4, 5, 6, 7, 8};
    vec_t  vt[$];

    ctrl_fsm #(.OPW(6), .ALUOPW(4), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne), .pc_src(pc_src),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .ALUOp(ALUOp), .instr_done(instr_done), .mem_err(mem_err),
        .illegal(illegal)
    );

    assign got = {pc_write, pc_write_cond, branch_ne, pc_src, iord, mem_read, mem_write, ir_write,
                  reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, ALUOp, instr_done, mem_err, illegal};

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got running, required finished");
        $fatal(1);
    end

    task automatic chk(input string name, input outs_t g, input outs_t e);
        n_chk++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (step %0d op %h t=%0t)", name, g, e, m_step, opcode, $time);
        end
    endtask

    task automatic chk_int(input string name, input int g, input int e);
        n_chk++;
        if (g != e) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, g, e, $time);
        end
    endtask

    function automatic outs_t ob(input int pcw, pcwc, bne, pcs, io, mr, mw, rw, rd, m2r, sa, sb, aop);
        outs_t o = '0;
        o.pc_write = 1'(pcw); o.pc_write_cond = 1'(pcwc); o.branch_ne = 1'(bne); o.pc_src = 2'(pcs);
        o.iord = 1'(io); o.mem_read = 1'(mr); o.mem_write = 1'(mw); o.reg_write = 1'(rw);
        o.reg_dst = 2'(rd); o.mem_to_reg = 2'(m2r); o.alu_src_a = 1'(sa); o.alu_src_b = 2'(sb);
        o.aluop = 4'(aop); o.instr_done = 1'b1;
        return o;
    endfunction

    task automatic add(input logic [5:0] op, input logic [5:0] f, input int lat, input outs_t o);
        vec_t v;
        v.op = op; v.f = f; v.lat = lat; v.fin = o;
        vt.push_back(v);
    endtask

    // Reference: step 0 fetch, 1 decode, 2+ the per-opcode cycle list; waits repeat a step.
    function automatic bit timed_out();
        bit w = (m_step == 0) || (m_step == 3 && (opcode == 8 || opcode == 9));
        return !rst && !m_trap && w && !mem_ready && m_wait == TMO - 1;
    endfunction

    function automatic outs_t model_out();
        outs_t o = '0;
        logic [5:0] op = opcode;
        if (rst) return o;
        if (m_trap) begin
            o.illegal = 1'b1;
            return o;
        end
        case (m_step)
            0: begin
                o.mem_read = 1'b1; o.alu_src_b = 2'd1; o.aluop = 4'd1;
                o.ir_write = mem_ready; o.pc_write = mem_ready;
            end
            1: begin
                o.alu_src_b = 2'd3; o.aluop = 4'd1; o.instr_done = (op > 13) && !TRAP;
            end
            2: begin
                if (op == 0) begin
                    o.alu_src_a = 1'b1;
                    if (funct == 15) begin o.pc_write = 1'b1; o.pc_src = 2'd3; o.instr_done = 1'b1; end
                end else if (op <= 7) begin
                    o.alu_src_a = 1'b1; o.alu_src_b = 2'd2; o.aluop = 4'(amap[op[2:0]]);
                end else if (op <= 9) begin
                    o.alu_src_a = 1'b1; o.alu_src_b = 2'd2; o.aluop = 4'd1;
                end else if (op <= 11) begin
                    o.alu_src_a = 1'b1; o.aluop = 4'd2; o.pc_write_cond = 1'b1; o.pc_src = 2'd1;
                    o.branch_ne = op == 11; o.instr_done = 1'b1;
                end else begin
                    o.pc_write = 1'b1; o.pc_src = 2'd2; o.instr_done = 1'b1;
                    if (op == 13) begin o.reg_write = 1'b1; o.reg_dst = 2'd2; o.mem_to_reg = 2'd2; end
                end
            end
            3: begin
                if (op == 8) begin
                    o.mem_read = 1'b1; o.iord = 1'b1;
                end else if (op == 9) begin
                    o.mem_write = 1'b1; o.iord = 1'b1; o.instr_done = mem_ready;
                end else begin
                    o.reg_write = 1'b1; o.reg_dst = (op == 0) ? 2'd1 : 2'd0; o.instr_done = 1'b1;
                end
            end
            default: begin
                o.reg_write = 1'b1; o.mem_to_reg = 2'd1; o.instr_done = 1'b1;
            end
        endcase
        o.mem_err = timed_out();
        return o;
    endfunction

    function automatic void model_advance();
        outs_t e;
        bit w = (m_step == 0) || (m_step == 3 && (opcode == 8 || opcode == 9));
        if (rst) begin
            m_step = 0; m_wait = 0; m_trap = 1'b0;
            return;
        end
        if (m_trap) return;
        if (timed_out()) begin
            m_step = 0; m_wait = 0;
            return;
        end
        if (w && !mem_ready) begin
            m_wait++;
            return;
        end
        m_wait = 0;
        e = model_out();
        if (m_step == 1 && opcode > 13 && TRAP) begin
            m_trap = 1'b1; m_step = 0;
        end else begin
            m_step = e.instr_done ? 0 : m_step + 1;
        end
    endfunction

    task automatic tick(output outs_t g);
        @(negedge clk);
        g = got;
        chk("cycle", g, model_out());
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] f, input int mode,
                             output int lat, output outs_t fin);
        outs_t g;
        opcode = op; funct = f; lat = -1; fin = '0;
        for (int c = 0; c < 200; c++) begin
            mem_ready = (mode == 0) ? 1'b1 : (mode == 1) ? !(c >= 3 && c <= 5) : ($urandom_range(0, 3) != 0);
            tick(g);
            if (g.instr_done) begin
                lat = c + 1; fin = g;
                break;
            end
        end
        if (lat < 0) begin
            n_chk++; n_fail++;
            $display("FAIL instr_budget: op %h got no instr_done in 200 cycles, required one", op);
        end
    endtask

    initial begin
        outs_t g, fin;
        int lat, n_err, err_at, r;
        logic [5:0] op, f;
        add(6'h00, 6'h01, 4, ob(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        add(6'h00, 6'h0F, 3, ob(1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        add(6'h01, 6'h00, 4, ob(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        add(6'h06, 6'h00, 4, ob(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        add(6'h08, 6'h00, 5, ob(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
        add(6'h09, 6'h00, 4, ob(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        add(6'h0A, 6'h00, 3, ob(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 2));
        add(6'h0B, 6'h00, 3, ob(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 2));
        add(6'h0C, 6'h00, 3, ob(1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add(6'h0D, 6'h00, 3, ob(1, 0, 0, 2, 0, 0, 0, 1, 2, 2, 0, 0, 0));
        if (!TRAP) add(6'h3F, 6'h00, 2, ob(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1));

        tick(g);
        tick(g);
        rst = 1'b0;

        foreach (vt[i]) begin
            run_instr(vt[i].op, vt[i].f, 0, lat, fin);
            chk_int($sformatf("latency_op%h_f%h", vt[i].op, vt[i].f), lat, vt[i].lat);
            chk($sformatf("final_op%h_f%h", vt[i].op, vt[i].f), fin, vt[i].fin);
        end

        run_instr(6'h08, 6'h00, 1, lat, fin);
        chk_int("lw_wait3_latency", lat, 8);

        opcode = 6'h00; funct = 6'h01; mem_ready = 1'b0; n_err = 0; err_at = -1;
        for (int c = 0; c < TMO; c++) begin
            tick(g);
            if (g.mem_err) begin n_err++; err_at = c; end
        end
        chk_int("fetch_timeout_pulses", n_err, 1);
        chk_int("fetch_timeout_cycle", err_at, TMO - 1);
        run_instr(6'h00, 6'h01, 0, lat, fin);
        chk_int("after_fetch_timeout_latency", lat, 4);

        opcode = 6'h08; mem_ready = 1'b1;
        for (int c = 0; c < 3; c++) tick(g);
        mem_ready = 1'b0; n_err = 0; err_at = -1;
        for (int c = 0; c < TMO; c++) begin
            tick(g);
            if (g.mem_err) begin n_err++; err_at = c; end
        end
        chk_int("memrd_timeout_pulses", n_err, 1);
        chk_int("memrd_timeout_cycle", err_at, TMO - 1);
        run_instr(6'h08, 6'h00, 0, lat, fin);
        chk_int("after_memrd_timeout_latency", lat, 5);

        opcode = 6'h09; funct = 6'h00; mem_ready = 1'b1;
        for (int c = 0; c < 3; c++) tick(g);
        rst = 1'b1;
        tick(g);
        chk_int("rst_in_memwr_mem_write", int'(g.mem_write), 0);
        rst = 1'b0; mem_ready = 1'b0;
        tick(g);
        chk_int("post_rst_fetch_mem_read", int'(g.mem_read), 1);
        run_instr(6'h09, 6'h00, 0, lat, fin);
        chk_int("post_rst_sw_latency", lat, 4);

        for (int i = 0; i < 80; i++) begin
            r = int'($urandom_range(0, TRAP ? 13 : 14));
            op = (r == 14) ? 6'($urandom_range(14, 63)) : 6'(r);
            f = ($urandom_range(0, 2) == 0) ? 6'h0F : 6'($urandom_range(0, 63));
            run_instr(op, f, 2, lat, fin);
        end

        if (TRAP) begin
            opcode = 6'h3F; mem_ready = 1'b1;
            for (int c = 0; c < 6; c++) tick(g);
            chk_int("trap_illegal_sticky", int'(g.illegal), 1);
            chk_int("trap_no_done", int'(g.instr_done), 0);
            rst = 1'b1;
            tick(g);
            rst = 1'b0;
            run_instr(6'h00, 6'h01, 0, lat, fin);
            chk_int("after_trap_illegal_cleared", int'(fin.illegal), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
